// File: rtl/conv_tap_mac.sv
`default_nettype none
// ============================================================================
//  Module   : conv_tap_mac
//  Purpose  : Single-output causal convolution over a 4-tap delay line.
//             On an accepted start the taps and bias are latched, then one
//             multiply-accumulate runs per cycle. The Q-format result is
//             floored, saturated to W bits and presented with a one-cycle
//             valid pulse. Weights sit in a 4-entry writable register file.
//  Ports    : clk, rst            - clock, asynchronous active-high reset
//             in_d0_i..in_d3_i    - signed taps (d0 oldest, d3 newest)
//             start_i, bias_i     - compute request and its signed bias
//             wgt_we_i/addr_i/data_i - weight register write port
//             busy_o              - high while in MAC or OUT
//             out_o, out_valid_o  - signed result and its one-cycle strobe
//             saturated_o         - result was clipped (held with out_o)
//  Revision : 1.0  initial release
// ============================================================================
module conv_tap_mac #(
    parameter int W     = 16,
    parameter int FRAC  = 12,
    parameter int ACC_W = 2*W+4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] in_d0_i,
    input  logic signed [W-1:0] in_d1_i,
    input  logic signed [W-1:0] in_d2_i,
    input  logic signed [W-1:0] in_d3_i,
    input  logic                start_i,
    input  logic signed [W-1:0] bias_i,
    input  logic                wgt_we_i,
    input  logic [1:0]          wgt_addr_i,
    input  logic signed [W-1:0] wgt_data_i,
    output logic                busy_o,
    output logic signed [W-1:0] out_o,
    output logic                out_valid_o,
    output logic                saturated_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                    state_q;
    logic [1:0]                k_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [W-1:0]       tap_q [4];
    logic signed [W-1:0]       wgt_q [4];
    logic signed [W-1:0]       out_q;
    logic                      out_valid_q;
    logic                      sat_q;

    logic                      w_accept;
    logic signed [2*W-1:0]     w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_bias_acc;
    logic signed [ACC_W-1:0]   w_shift;
    logic                      w_fits;
    logic signed [W-1:0]       w_clamp;

    // The OUT cycle also takes a new start so results can be issued
    // back-to-back every 5 cycles; MAC cycles ignore start.
    assign w_accept   = start_i && ((state_q == S_IDLE) || (state_q == S_OUT));

    assign w_prod     = tap_q[k_q] * wgt_q[k_q];
    assign w_prod_ext = {{(ACC_W-2*W){w_prod[2*W-1]}}, w_prod};
    assign w_bias_acc = {{(ACC_W-W){bias_i[W-1]}}, bias_i} <<< FRAC;

    // Arithmetic shift floors toward -inf. The value fits in W bits only
    // when every bit from W-1 upward equals the sign bit.
    assign w_shift    = acc_q >>> FRAC;
    assign w_fits     = (w_shift[ACC_W-1:W-1] == {(ACC_W-W+1){w_shift[W-1]}});
    assign w_clamp    = w_fits ? w_shift[W-1:0]
                      : (w_shift[ACC_W-1] ? {1'b1, {(W-1){1'b0}}}
                                          : {1'b0, {(W-1){1'b1}}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= 2'd0;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                tap_q[i] <= '0;
                wgt_q[i] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // A write landing with an accepted start is dropped.
                    if (!w_accept && wgt_we_i) begin
                        wgt_q[wgt_addr_i] <= wgt_data_i;
                    end
                end
                S_MAC: begin
                    acc_q <= acc_q + w_prod_ext;
                    k_q   <= k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        state_q <= S_OUT;
                    end
                end
                S_OUT: begin
                    out_q       <= w_clamp;
                    sat_q       <= ~w_fits;
                    out_valid_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            if (w_accept) begin
                tap_q[0] <= in_d0_i;
                tap_q[1] <= in_d1_i;
                tap_q[2] <= in_d2_i;
                tap_q[3] <= in_d3_i;
                acc_q    <= w_bias_acc;
                k_q      <= 2'd0;
                state_q  <= S_MAC;
            end
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign out_o       = out_q;
    assign out_valid_o = out_valid_q;
    assign saturated_o = sat_q;

endmodule
`default_nettype wire
